// File: rtl/mem_pkg.sv
// Shared types and constants for the CPU-to-byte-RAM access unit.
package mem_pkg;

    localparam int unsigned MEM_DEPTH_DEFAULT = 200;
    localparam int unsigned ADDR_W            = 8;
    localparam int unsigned DATA_W            = 32;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN,
        RESP
    } state_e;

    typedef struct packed {
        logic              we;
        size_e             size;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    // Index of the last byte of an access (B-1); illegal sizes map to 0.
    function automatic logic [1:0] size_last(input size_e size);
        case (size)
            SZ_HALF: size_last = 2'd1;
            SZ_WORD: size_last = 2'd3;
            default: size_last = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Little-endian load assembly with zero or sign extension of the upper bytes.
// Sign extension is enabled by defining MEM_ACCESS_SIGNEXT_EN.
module mem_load_align
    import mem_pkg::*;
(
    input  logic [DATA_W-1:0] cap,
    input  size_e             size,
    output logic [DATA_W-1:0] rdata_c
);

`ifdef MEM_ACCESS_SIGNEXT_EN
    localparam bit SIGN_EXT = 1'b1;
`else
    localparam bit SIGN_EXT = 1'b0;
`endif

    always_comb begin
        rdata_c = cap;
        case (size)
            SZ_BYTE: rdata_c = {{24{SIGN_EXT & cap[7]}}, cap[7:0]};
            SZ_HALF: rdata_c = {{16{SIGN_EXT & cap[15]}}, cap[15:0]};
            default: rdata_c = cap;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Serialises CPU byte/half/word loads and stores onto a byte-wide RAM with
// one-cycle registered read latency. Load extension set by MEM_ACCESS_SIGNEXT_EN.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned N         = 8,
    parameter int unsigned MEM_DEPTH = MEM_DEPTH_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              ram_sw,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [N-1:0]      ram_din,
    input  logic [N-1:0]      ram_dout
);

    state_e              state_q, state_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [1:0]          last_q, last_d;
    req_t                req_q, req_d;
    logic [DATA_W-1:0]   cap_q, cap_d;
    logic                cap_pend_q, cap_pend_d;
    logic [1:0]          cap_idx_q, cap_idx_d;

    logic                req_ready_d, rsp_valid_d, rsp_err_d, ram_sw_d;
    logic [DATA_W-1:0]   rsp_rdata_d;
    logic [ADDR_W-1:0]   ram_addr_d;
    logic [N-1:0]        ram_din_d;

    logic [1:0]          acc_last_c;
    logic [ADDR_W:0]     acc_end_c;
    logic                acc_err_c;
    logic [DATA_W-1:0]   align_c;

    // Assembly sees the byte being captured this cycle so DRAIN can respond directly.
    mem_load_align u_align (
        .cap     (cap_d),
        .size    (req_q.size),
        .rdata_c (align_c)
    );

    // Request legality: illegal size, misalignment, or running past the last location.
    always_comb begin
        acc_last_c = size_last(size_e'(req_size));
        acc_end_c  = {1'b0, req_addr} + {7'b0, acc_last_c};
        acc_err_c  = (size_e'(req_size) == SZ_ILL)
                  || ((req_addr[1:0] & acc_last_c) != 2'b00)
                  || (acc_end_c > 9'(MEM_DEPTH - 1));
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        req_d       = req_q;
        cap_d       = cap_q;
        cap_pend_d  = 1'b0;
        cap_idx_d   = 2'd0;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        ram_sw_d    = 1'b0;
        ram_addr_d  = '0;
        ram_din_d   = '0;

        if (cap_pend_q) begin
            cap_d[{cap_idx_q, 3'b000} +: 8] = 8'(ram_dout);
        end

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    req_d  = '{we: req_we, size: size_e'(req_size), addr: req_addr, wdata: req_wdata};
                    last_d = acc_last_c;
                    cnt_d  = 2'd0;
                    cap_d  = '0;
                    if (acc_err_c) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else if (req_we) begin
                        state_d    = WRITE;
                        ram_sw_d   = 1'b1;
                        ram_addr_d = req_addr;
                        ram_din_d  = N'(req_wdata[7:0]);
                    end else begin
                        state_d    = READ;
                        ram_addr_d = req_addr;
                    end
                end
            end
            WRITE: begin
                if (cnt_q == last_q) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                end else begin
                    cnt_d      = cnt_q + 2'd1;
                    ram_sw_d   = 1'b1;
                    ram_addr_d = req_q.addr + 8'(cnt_d);
                    ram_din_d  = N'(req_q.wdata[{cnt_d, 3'b000} +: 8]);
                end
            end
            READ: begin
                // Address driven this cycle returns data next cycle.
                cap_pend_d = 1'b1;
                cap_idx_d  = cnt_q;
                if (cnt_q == last_q) begin
                    state_d = DRAIN;
                end else begin
                    cnt_d      = cnt_q + 2'd1;
                    ram_addr_d = req_q.addr + 8'(cnt_d);
                end
            end
            DRAIN: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = align_c;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            last_q     <= '0;
            req_q      <= '0;
            cap_q      <= '0;
            cap_pend_q <= 1'b0;
            cap_idx_q  <= '0;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_rdata  <= '0;
            ram_sw     <= 1'b0;
            ram_addr   <= '0;
            ram_din    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            req_q      <= req_d;
            cap_q      <= cap_d;
            cap_pend_q <= cap_pend_d;
            cap_idx_q  <= cap_idx_d;
            req_ready  <= req_ready_d;
            rsp_valid  <= rsp_valid_d;
            rsp_err    <= rsp_err_d;
            rsp_rdata  <= rsp_rdata_d;
            ram_sw     <= ram_sw_d;
            ram_addr   <= ram_addr_d;
            ram_din    <= ram_din_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a byte-wide registered RAM model.
module tb_mem_access_unit;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we;
    logic [1:0]  req_size;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        ram_sw;
    logic [7:0]  ram_addr, ram_din, ram_dout;

    logic [7:0]  mem [0:255];

    int n_checks = 0;
    int n_errors = 0;

`ifdef MEM_ACCESS_SIGNEXT_EN
    localparam logic [31:0] EXP_B13 = 32'hFFFF_FFDE;
    localparam logic [31:0] EXP_H12 = 32'hFFFF_DEAD;
`else
    localparam logic [31:0] EXP_B13 = 32'h0000_00DE;
    localparam logic [31:0] EXP_H12 = 32'h0000_DEAD;
`endif

    mem_access_unit #(.N(8), .MEM_DEPTH(200)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_size  (req_size),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .ram_sw    (ram_sw),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_sw) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic run_req(input string tag, input logic we, input logic [1:0] size,
                           input logic [7:0] addr, input logic [31:0] wdata,
                           input int exp_lat, input logic [31:0] exp_rdata,
                           input logic exp_err, input int exp_sw);
        int lat;
        int n_sw;
        int w;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_size  = size;
        req_addr  = addr;
        req_wdata = wdata;
        w = 0;
        while (!req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk({tag, " accept"}, 32'(req_ready), 32'd1);
        lat  = 0;
        n_sw = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (ram_sw) n_sw++;
            if (rsp_valid) begin
                lat = i;
                chk({tag, " rdata"}, rsp_rdata, exp_rdata);
                chk({tag, " err"}, 32'(rsp_err), 32'(exp_err));
            end
        end
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " sw_cycles"}, 32'(n_sw), 32'(exp_sw));
        @(negedge clk);
        chk({tag, " ready_after"}, {30'd0, rsp_valid, req_ready}, 32'd1);
    endtask

    initial begin
        int rsp1, acc2, rsp2, seen;
        logic [31:0] rd2;

        reset     = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_size  = 2'b00;
        req_addr  = 8'h00;
        req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        chk("reset ready/valid/err/sw", {28'd0, req_ready, rsp_valid, rsp_err, ram_sw}, 32'h8);
        chk("reset addr/din", {16'd0, ram_addr, ram_din}, 32'h0);
        chk("reset rdata", rsp_rdata, 32'h0);
        reset = 1'b0;

        // Store then reload a word, then sub-word loads of the same bytes
        run_req("st_w10", 1'b1, 2'b10, 8'h10, 32'hDEAD_BEEF, 5, 32'h0, 1'b0, 4);
        chk("mem 10..13", {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]}, 32'hDEAD_BEEF);
        run_req("ld_w10", 1'b0, 2'b10, 8'h10, 32'h0, 6, 32'hDEAD_BEEF, 1'b0, 0);
        run_req("ld_b13", 1'b0, 2'b00, 8'h13, 32'h0, 3, EXP_B13, 1'b0, 0);
        run_req("ld_h12", 1'b0, 2'b01, 8'h12, 32'h0, 4, EXP_H12, 1'b0, 0);

        // Half and byte stores use only the low bytes of wdata
        run_req("st_h20", 1'b1, 2'b01, 8'h20, 32'hFFFF_1234, 3, 32'h0, 1'b0, 2);
        run_req("ld_h20", 1'b0, 2'b01, 8'h20, 32'h0, 4, 32'h0000_1234, 1'b0, 0);
        run_req("st_b31", 1'b1, 2'b00, 8'h31, 32'hAAAA_AA7F, 2, 32'h0, 1'b0, 1);
        run_req("ld_b31", 1'b0, 2'b00, 8'h31, 32'h0, 3, 32'h0000_007F, 1'b0, 0);

        // Upper address boundary: 196..199 legal, 200 and beyond rejected
        run_req("st_wC4", 1'b1, 2'b10, 8'hC4, 32'h0102_0304, 5, 32'h0, 1'b0, 4);
        run_req("ld_wC4", 1'b0, 2'b10, 8'hC4, 32'h0, 6, 32'h0102_0304, 1'b0, 0);
        run_req("ld_bC7", 1'b0, 2'b00, 8'hC7, 32'h0, 3, 32'h0000_0001, 1'b0, 0);
        run_req("err_wC6", 1'b1, 2'b10, 8'hC6, 32'h1111_1111, 1, 32'h0, 1'b1, 0);
        run_req("err_h11", 1'b0, 2'b01, 8'h11, 32'h0, 1, 32'h0, 1'b1, 0);
        run_req("err_sz3", 1'b1, 2'b11, 8'h00, 32'h2222_2222, 1, 32'h0, 1'b1, 0);
        run_req("err_bC8", 1'b0, 2'b00, 8'hC8, 32'h0, 1, 32'h0, 1'b1, 0);
        run_req("err_wFC", 1'b0, 2'b10, 8'hFC, 32'h0, 1, 32'h0, 1'b1, 0);
        chk("mem untouched by errors", {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]}, 32'hDEAD_BEEF);

        // Reset in the second cycle of a word store aborts after two bytes
        run_req("st_w40", 1'b1, 2'b10, 8'h40, 32'h1122_3344, 5, 32'h0, 1'b0, 4);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'b10;
        req_addr  = 8'h40;
        req_wdata = 32'hAABB_CCDD;
        chk("abort accept", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort sw/ready", {30'd0, ram_sw, req_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk("abort no rsp", 32'(seen), 32'd0);
        chk("abort mem 40..43", {mem[8'h43], mem[8'h42], mem[8'h41], mem[8'h40]}, 32'h1122_CCDD);

        // Back-to-back: req_valid held, second request waits for the cycle after rsp_valid
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'b00;
        req_addr  = 8'h50;
        req_wdata = 32'h0000_0055;
        chk("b2b first ready", 32'(req_ready), 32'd1);
        rsp1 = 0;
        acc2 = 0;
        rsp2 = 0;
        rd2  = 32'h0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 1) req_we = 1'b0;
            if (acc2 != 0 && i == acc2 + 1) req_valid = 1'b0;
            if (rsp_valid && rsp1 == 0) begin
                rsp1 = i;
            end else if (rsp_valid && acc2 != 0 && rsp2 == 0) begin
                rsp2 = i;
                rd2  = rsp_rdata;
            end
            if (req_ready && req_valid && acc2 == 0) acc2 = i;
        end
        chk("b2b first rsp", 32'(rsp1), 32'd2);
        chk("b2b second accept", 32'(acc2), 32'd3);
        chk("b2b second rsp", 32'(rsp2), 32'd6);
        chk("b2b second rdata", rd2, 32'h0000_0055);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
